// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and multiplier:
// opcode encodings, multiply-type encodings, CPSR bit positions and
// the packed NZCV flag layout.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

  localparam logic [2:0] MT_MUL   = 3'b000;
  localparam logic [2:0] MT_MLA   = 3'b001;
  localparam logic [2:0] MT_UMULL = 3'b100;
  localparam logic [2:0] MT_UMLAL = 3'b101;
  localparam logic [2:0] MT_SMULL = 3'b110;
  localparam logic [2:0] MT_SMLAL = 3'b111;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_multiplier_if.sv
// Operand/result bundle between the register-read stage and the
// execute datapath. The master drives operands; the slave (datapath)
// drives the registered results.
interface alu_multiplier_if;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] c_i;
  logic [31:0] d_i;
  logic [31:0] cpsr_i;
  logic [3:0]  opcode_i;
  logic [2:0]  type_i;
  logic [31:0] result_o;
  logic [63:0] m_result_o;
  logic [3:0]  flags_o;

  modport master (
    output a_i, b_i, c_i, d_i, cpsr_i, opcode_i, type_i,
    input  result_o, m_result_o, flags_o
  );

  modport slave (
    input  a_i, b_i, c_i, d_i, cpsr_i, opcode_i, type_i,
    output result_o, m_result_o, flags_o
  );
endinterface

// File: rtl/alu_multiplier_mul_core.sv
// mul_core: combinational 32x32 multiply-accumulate.
// With ALU_LONG_MULTIPLY_EN defined it forms the full 64-bit signed or
// unsigned product plus a 64-bit accumulator; otherwise only the low
// 32-bit product plus low accumulate word is built.
module mul_core (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] acc_i,
  input  logic        signed_i,
  output logic [63:0] prod_o
);

`ifdef ALU_LONG_MULTIPLY_EN
  // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64
  // product are then the exact 32x32 product in either signedness.
  logic [63:0] a_ext;
  logic [63:0] b_ext;

  assign a_ext  = {{32{signed_i & a_i[31]}}, a_i};
  assign b_ext  = {{32{signed_i & b_i[31]}}, b_i};
  assign prod_o = a_ext * b_ext + acc_i;
`else
  logic [31:0] prod_lo;
  logic        unused_long;

  assign prod_lo     = a_i * b_i + acc_i[31:0];
  assign prod_o      = {32'd0, prod_lo};
  assign unused_long = &{1'b0, signed_i, acc_i[63:32]};
`endif

endmodule

// File: rtl/alu_multiplier.sv
// alu_multiplier: execute-stage ALU (16 ARM data-processing opcodes with
// NZCV generation) and 32x32 multiplier, both registered once.
// Optional feature macro: ALU_LONG_MULTIPLY_EN enables the 64-bit
// UMULL/UMLAL/SMULL/SMLAL forms; without it those types return zero.
module alu_multiplier
  import alu_pkg::*;
(
  input logic              clk,
  input logic              rst,
  alu_multiplier_if.slave  bus
);

  logic [31:0] ax, ay, logic_res, result_d, result_q;
  logic        cin, arith;
  logic [32:0] sum;
  flags_t      flags_d, flags_q;
  logic        mul_signed;
  logic [63:0] mul_acc, mul_prod, m_result_d, m_result_q;
  logic        unused_cpsr;

  // Steer operands into a single adder: subtracts use x + ~y + carry-in.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ax        = bus.a_i;
    ay        = bus.b_i;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (alu_op_e'(bus.opcode_i))
      OP_AND, OP_TST: begin arith = 1'b0; logic_res = bus.a_i & bus.b_i;  end
      OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = bus.a_i ^ bus.b_i;  end
      OP_SUB, OP_CMP: begin ay = ~bus.b_i; cin = 1'b1;                    end
      OP_RSB:         begin ax = bus.b_i; ay = ~bus.a_i; cin = 1'b1;      end
      OP_ADD, OP_CMN: begin cin = 1'b0;                                   end
      OP_ADC:         begin cin = bus.cpsr_i[CPSR_C];                     end
      OP_SBC:         begin ay = ~bus.b_i; cin = bus.cpsr_i[CPSR_C];      end
      OP_RSC:         begin ax = bus.b_i; ay = ~bus.a_i;
                            cin = bus.cpsr_i[CPSR_C];                     end
      OP_ORR:         begin arith = 1'b0; logic_res = bus.a_i | bus.b_i;  end
      OP_MOV:         begin arith = 1'b0; logic_res = bus.b_i;            end
      OP_BIC:         begin arith = 1'b0; logic_res = bus.a_i & ~bus.b_i; end
      OP_MVN:         begin arith = 1'b0; logic_res = ~bus.b_i;           end
      default:        ;
    endcase
  end

  // Carry out of the inverted-operand adder is already ARM's NOT-borrow.
  assign sum       = {1'b0, ax} + {1'b0, ay} + {32'd0, cin};
  assign result_d  = arith ? sum[31:0] : logic_res;
  assign flags_d.n = result_d[31];
  assign flags_d.z = (result_d == 32'd0);
  assign flags_d.c = arith ? sum[32] : bus.cpsr_i[CPSR_C];
  assign flags_d.v = arith ? ((ax[31] == ay[31]) && (sum[31] != ax[31]))
                           : bus.cpsr_i[CPSR_V];

  assign unused_cpsr = &{1'b0, bus.cpsr_i[CPSR_N], bus.cpsr_i[CPSR_Z],
                         bus.cpsr_i[27:0]};

  // Select signedness and accumulator for the multiply type.
  always_comb begin
    mul_signed = 1'b0;
    mul_acc    = '0;
    case (bus.type_i)
      MT_MLA:   mul_acc = {32'd0, bus.c_i};
      MT_UMLAL: mul_acc = {bus.d_i, bus.c_i};
      MT_SMULL: mul_signed = 1'b1;
      MT_SMLAL: begin mul_signed = 1'b1; mul_acc = {bus.d_i, bus.c_i}; end
      default:  ;
    endcase
  end

  mul_core u_mul_core (
    .a_i      (bus.a_i),
    .b_i      (bus.b_i),
    .acc_i    (mul_acc),
    .signed_i (mul_signed),
    .prod_o   (mul_prod)
  );

  // Shape the multiplier result: short forms keep only the low word.
  always_comb begin
    m_result_d = '0;
    case (bus.type_i)
      MT_MUL, MT_MLA: m_result_d = {32'd0, mul_prod[31:0]};
`ifdef ALU_LONG_MULTIPLY_EN
      MT_UMULL, MT_UMLAL, MT_SMULL, MT_SMLAL: m_result_d = mul_prod;
`endif
      default:        m_result_d = '0;
    endcase
  end

`ifndef ALU_LONG_MULTIPLY_EN
  logic unused_mul_hi;
  assign unused_mul_hi = &{1'b0, mul_prod[63:32]};
`endif

  // Output registers for both units; cleared asynchronously by rst.
  // NOTE: state is updated with non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      flags_q    <= '0;
      m_result_q <= '0;
    end else begin
      result_q   <= result_d;
      flags_q    <= flags_d;
      m_result_q <= m_result_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.flags_o    = flags_q;
  assign bus.m_result_o = m_result_q;

endmodule

// File: tb/tb_alu_multiplier.sv
// Scoreboard bench for alu_multiplier: the driver pushes hand-computed
// expectations as it issues each vector; a monitor pops and compares
// one entry per clock after the capturing edge.
module tb_alu_multiplier;
  import alu_pkg::*;

`ifdef ALU_LONG_MULTIPLY_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [63:0] m_result;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  alu_multiplier_if bus ();

  alu_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one vector mid-cycle and queue what the next edge must produce.
  task automatic issue(input string name, input logic [3:0] op,
                       input logic [2:0] mt, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic [31:0] cpsr,
                       input logic [31:0] exp_r, input logic [3:0] exp_f,
                       input logic [63:0] exp_m);
    exp_t e;
    @(negedge clk);
    bus.a_i      = a;
    bus.b_i      = b;
    bus.c_i      = c;
    bus.d_i      = d;
    bus.cpsr_i   = cpsr;
    bus.opcode_i = op;
    bus.type_i   = mt;
    e.name     = name;
    e.result   = exp_r;
    e.flags    = exp_f;
    e.m_result = exp_m;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] lng(input logic [63:0] v);
    return LONG_EN ? v : 64'd0;
  endfunction

  // Monitor: outputs are valid every cycle, so compare 1 ns after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".result"},   {32'd0, bus.result_o}, {32'd0, e.result});
        check({e.name, ".flags"},    {60'd0, bus.flags_o},  {60'd0, e.flags});
        check({e.name, ".m_result"}, bus.m_result_o,        e.m_result);
      end
    end
  end

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, required 0", sb.size());
  endtask

  initial begin
    bus.a_i = '0; bus.b_i = '0; bus.c_i = '0; bus.d_i = '0;
    bus.cpsr_i = '0; bus.opcode_i = '0; bus.type_i = 3'b010;

    // Reset state with clocks running.
    repeat (2) @(posedge clk);
    #2;
    check("reset.result",   {32'd0, bus.result_o}, 64'd0);
    check("reset.flags",    {60'd0, bus.flags_o},  64'd0);
    check("reset.m_result", bus.m_result_o,        64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU vectors (reserved multiply type keeps m_result at 0).
    issue("add_wrap", OP_ADD, 3'b010, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0,
          32'h0000_0000, 4'b0110, 64'd0);
    issue("sub_ovf",  OP_SUB, 3'b010, 32'h8000_0000, 32'h1, 0, 0, 32'h0,
          32'h7FFF_FFFF, 4'b0011, 64'd0);
    issue("adc_c1",   OP_ADC, 3'b010, 32'h1, 32'h2, 0, 0, 32'h2000_0000,
          32'h4, 4'b0000, 64'd0);
    issue("sbc_c0",   OP_SBC, 3'b010, 32'h5, 32'h3, 0, 0, 32'h0,
          32'h1, 4'b0010, 64'd0);
    issue("mov_pass", OP_MOV, 3'b010, 32'h0, 32'hA5, 0, 0, 32'h3000_0000,
          32'hA5, 4'b0011, 64'd0);
    issue("sub_5_3",  OP_SUB, 3'b010, 32'h5, 32'h3, 0, 0, 32'h0,
          32'h2, 4'b0010, 64'd0);
    issue("sub_3_5",  OP_SUB, 3'b010, 32'h3, 32'h5, 0, 0, 32'h0,
          32'hFFFF_FFFE, 4'b1000, 64'd0);
    issue("rsb",      OP_RSB, 3'b010, 32'h1, 32'h0, 0, 0, 32'h0,
          32'hFFFF_FFFF, 4'b1000, 64'd0);
    issue("and_pass", OP_AND, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0,
          32'hF000_0000, 32'hF000_F000, 4'b1011, 64'd0);
    issue("eor_zero", OP_EOR, 3'b010, 32'h1234_5678, 32'h1234_5678, 0, 0,
          32'h0, 32'h0, 4'b0100, 64'd0);
    issue("orr",      OP_ORR, 3'b010, 32'h0000_FFFF, 32'hFFFF_0000, 0, 0,
          32'h0, 32'hFFFF_FFFF, 4'b1000, 64'd0);
    issue("bic",      OP_BIC, 3'b010, 32'hFFFF_FFFF, 32'h0000_FFFF, 0, 0,
          32'h2000_0000, 32'hFFFF_0000, 4'b1010, 64'd0);
    issue("mvn",      OP_MVN, 3'b010, 32'h0, 32'h0, 0, 0, 32'h0,
          32'hFFFF_FFFF, 4'b1000, 64'd0);
    issue("cmp_eq",   OP_CMP, 3'b010, 32'h7, 32'h7, 0, 0, 32'h0,
          32'h0, 4'b0110, 64'd0);
    issue("cmn_ovf",  OP_CMN, 3'b010, 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h0,
          32'h8000_0000, 4'b1001, 64'd0);
    issue("tst",      OP_TST, 3'b010, 32'h1, 32'h2, 0, 0, 32'h0,
          32'h0, 4'b0100, 64'd0);
    issue("teq",      OP_TEQ, 3'b010, 32'h3, 32'h1, 0, 0, 32'h0,
          32'h2, 4'b0000, 64'd0);
    issue("rsc_c0",   OP_RSC, 3'b010, 32'h3, 32'h5, 0, 0, 32'h0,
          32'h1, 4'b0010, 64'd0);
    issue("adc_wrap", OP_ADC, 3'b010, 32'hFFFF_FFFF, 32'h0, 0, 0,
          32'h2000_0000, 32'h0, 4'b0110, 64'd0);

    // Multiplier vectors (MOV passes b to result, cpsr=0).
    issue("mul",      OP_MOV, MT_MUL, 32'h3, 32'h4, 0, 0, 32'h0,
          32'h4, 4'b0000, 64'd12);
    issue("mla",      OP_MOV, MT_MLA, 32'h3, 32'h4, 32'h5, 0, 32'h0,
          32'h4, 4'b0000, 64'd17);
    issue("mul_trunc", OP_MOV, MT_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
          32'h0, 32'hFFFF_FFFF, 4'b1000, 64'd1);
    issue("mla_trunc", OP_MOV, MT_MLA, 32'h0001_0000, 32'h0001_0000,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0001_0000, 4'b0000,
          64'h0000_0000_FFFF_FFFF);
    issue("umull",    OP_MOV, MT_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
          32'h0, 32'hFFFF_FFFF, 4'b1000, lng(64'hFFFF_FFFE_0000_0001));
    issue("smull",    OP_MOV, MT_SMULL, 32'hFFFF_FFFF, 32'h2, 0, 0, 32'h0,
          32'h2, 4'b0000, lng(64'hFFFF_FFFF_FFFF_FFFE));
    issue("smlal",    OP_MOV, MT_SMLAL, 32'hFFFF_FFFF, 32'h2, 32'h4, 32'h0,
          32'h0, 32'h2, 4'b0000, lng(64'd2));
    issue("umlal",    OP_MOV, MT_UMLAL, 32'h2, 32'h3, 32'hFFFF_FFFF, 32'h0,
          32'h0, 32'h3, 4'b0000, lng(64'h0000_0001_0000_0005));
    issue("umlal_wrap", OP_MOV, MT_UMLAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 4'b1000,
          lng(64'hFFFF_FFFE_0000_0000));
    issue("smull_min", OP_MOV, MT_SMULL, 32'h8000_0000, 32'h8000_0000, 0, 0,
          32'h0, 32'h8000_0000, 4'b1000, lng(64'h4000_0000_0000_0000));
    issue("reserved", OP_MOV, 3'b011, 32'h3, 32'h4, 0, 0, 32'h0,
          32'h4, 4'b0000, 64'd0);

    // Nonzero outputs on every field, then asynchronous reset mid-cycle.
    issue("pre_reset", OP_ADD, MT_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
          32'h0, 32'hFFFF_FFFE, 4'b1010, 64'd1);
    drain();
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.result",   {32'd0, bus.result_o}, 64'd0);
    check("async_rst.flags",    {60'd0, bus.flags_o},  64'd0);
    check("async_rst.m_result", bus.m_result_o,        64'd0);
    @(posedge clk);
    #1;
    check("rst_hold.result", {32'd0, bus.result_o}, 64'd0);
    #2;
    rst = 1'b0;
    issue("post_reset", OP_SUB, MT_MLA, 32'h3, 32'h5, 32'h7, 0, 32'h0,
          32'hFFFF_FFFE, 4'b1000, 64'd22);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
